// File: rtl/neuron_mac_stream.sv
// neuron_mac_stream: one fully-connected neuron slot.
//   Weights and bias arrive over a shared config bus. A write is taken only when
//   it targets this instance's layer/neuron ID. The neuron then streams NUM_WEIGHT
//   inputs and accumulates the signed products, with saturation on every add.
//   After the last input it adds the bias, applies linear or ReLU activation and
//   presents a single result.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   cfg_*                    config bus (write strobe, bias/weight select,
//                            pointer reset, layer/neuron ID, payload);
//                            cfg_err is sticky and reports a write dropped
//                            because the neuron was busy
//   act_relu                 activation select, captured in BIAS
//   in_data/valid/ready      input sample stream
//   out_data/valid/ready     result handshake
module neuron_mac_stream #(
  parameter int LAYER_NO   = 4,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 10,
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_is_bias,
  input  logic              cfg_ptr_rst,
  input  logic [31:0]       cfg_layer,
  input  logic [31:0]       cfg_neuron,
  input  logic [31:0]       cfg_data,
  output logic              cfg_err,
  input  logic              act_relu,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int AW = 2 * DATA_W;
  localparam int CW = $clog2(NUM_WEIGHT);
  localparam logic [CW-1:0] LAST = CW'(NUM_WEIGHT - 1);
  localparam logic signed [AW-1:0] OMAX = AW'((64'sd1 <<< (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN = -OMAX - 1;

  typedef enum logic [2:0] {ACCUM, DRAIN, BIAS, ACT, OUT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, wptr_q, wptr_d;
  logic                    drn_q, drn_d;
  logic [1:0]              vld_q, vld_d;
  logic signed [AW-1:0]    acc_q, acc_d, prod_q, prod_d;
  logic [DATA_W-1:0]       bias_q, bias_d, out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, err_q, err_d, relu_q, relu_d;
  logic signed [DATA_W-1:0] w_q, x_q;
  logic [DATA_W-1:0]       ram [NUM_WEIGHT];
  logic                    accept, idle, id_hit, wr_en;
  logic signed [AW-1:0]    bias_ext, shifted;
  logic                    unused_cfg;

  assign unused_cfg = ^cfg_data[31:DATA_W];

  // Saturating add: overflow only when both operands share a sign and the sum flips it.
  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    logic signed [AW-1:0] s;
    s = a + b;
    if (a[AW-1] == b[AW-1] && s[AW-1] != a[AW-1])
      s = a[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    return s;
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = err_q;
  assign accept    = in_valid & in_ready;
  assign idle      = (state_q == ACCUM) && (cnt_q == '0);
  assign id_hit    = (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO)) &&
                     (cfg_we | cfg_ptr_rst);
  assign bias_ext  = {{(AW-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_W;
  assign shifted   = acc_q >>> FRAC_W;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    drn_d       = drn_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    relu_d      = relu_q;
    wr_en       = 1'b0;
    // Two-stage product pipe: stage 0 = weight read + input latched, stage 1 = product.
    vld_d       = {vld_q[0], accept};

    if (id_hit) begin
      if (!idle)            err_d = 1'b1;
      else if (cfg_ptr_rst) wptr_d = '0;
      else if (cfg_is_bias) bias_d = cfg_data[DATA_W-1:0];
      else begin
        wr_en  = 1'b1;
        wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      end
    end

    if (vld_q[0]) prod_d = w_q * x_q;
    if (vld_q[1]) acc_d  = sat_add(acc_q, prod_q);

    case (state_q)
      ACCUM: if (accept) begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else cnt_d = cnt_q + 1'b1;
      end
      DRAIN: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = BIAS;
      end
      BIAS: begin
        acc_d   = sat_add(acc_q, bias_ext);
        relu_d  = act_relu;
        state_d = ACT;
      end
      ACT: begin
        if (shifted > OMAX)      out_data_d = OMAX[DATA_W-1:0];
        else if (shifted < OMIN) out_data_d = OMIN[DATA_W-1:0];
        else                     out_data_d = shifted[DATA_W-1:0];
        if (relu_q && shifted[AW-1]) out_data_d = '0;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        acc_d       = '0;
        state_d     = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      wptr_q      <= '0;
      drn_q       <= 1'b0;
      vld_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      relu_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      drn_q       <= drn_d;
      vld_q       <= vld_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      relu_q      <= relu_d;
    end
  end

  // Weight RAM and read-side data registers are not reset; qualified by vld_q.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wptr_q] <= cfg_data[DATA_W-1:0];
    if (accept) begin
      w_q <= ram[cnt_q];
      x_q <= in_data;
    end
  end
endmodule
